// File: rtl/grf_mp_if.sv
// grf_mp_if: bundle of the register-file read, write and clear-handshake signals.
//
// Parameters: DATA_W (register width), ADDR_W (address width).
// Modports:
//   master - the decode/writeback side: drives addresses, write ports and clr_req,
//            and receives read data and the clear handshake.
//   slave  - the register file (grf_mp).
interface grf_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr0;
    logic [DATA_W-1:0] rd_data0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic              wr_en0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [DATA_W-1:0] wr_data0;
    logic              wr_en1;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data1;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output rd_addr0, rd_addr1,
        output wr_en0, wr_addr0, wr_data0,
        output wr_en1, wr_addr1, wr_data1,
        output clr_req,
        input  rd_data0, rd_data1, clr_busy, clr_done
    );

    modport slave (
        input  rd_addr0, rd_addr1,
        input  wr_en0, wr_addr0, wr_data0,
        input  wr_en1, wr_addr1, wr_data1,
        input  clr_req,
        output rd_data0, rd_data1, clr_busy, clr_done
    );
endinterface

// File: rtl/grf_mp.sv
// grf_mp: two-read / two-write general register file with a sequential clear engine.
//
// Ports:
//   clk    - rising-edge clock.
//   reset  - synchronous active-low reset; zeroes the array and idles the clear engine.
//   bus    - grf_mp_if.slave: rd_addr0/1 -> rd_data0/1 (combinational reads),
//            wr_en0/1, wr_addr0/1, wr_data0/1 (port 1 wins on a same-address write),
//            clr_req in, clr_busy / clr_done out.
//
// Parameters: DATA_W, ADDR_W (NREGS = 2**ADDR_W), ZERO_REG (entry 0 hardwired to 0).
// Build option: define GRF_MP_BYPASS_EN for write-first forwarding of same-cycle writes
// onto the read ports; undefined gives read-first behaviour.
module grf_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     reset,
    grf_mp_if.slave  bus
);
    localparam int unsigned NREGS = 1 << ADDR_W;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSweep = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [ADDR_W-1:0] LastIdx = '1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [NREGS];

    logic              wr_ok0, wr_ok1;
    logic [DATA_W-1:0] rd_data0, rd_data1;

    // Writes are dropped (not buffered) while the sweep owns the array.
    assign wr_ok0 = bus.wr_en0 && (state_q != StSweep) &&
                    !((ZERO_REG == 1) && (bus.wr_addr0 == '0));
    assign wr_ok1 = bus.wr_en1 && (state_q != StSweep) &&
                    !((ZERO_REG == 1) && (bus.wr_addr1 == '0));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end
            end
            StSweep: begin
                // Stop on the last entry rather than letting idx wrap into a second pass.
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == StSweep) begin
                mem_q[idx_q] <= '0;
            end else begin
                if (wr_ok0) mem_q[bus.wr_addr0] <= bus.wr_data0;
                // Later assignment takes effect, so port 1 wins a same-address conflict.
                if (wr_ok1) mem_q[bus.wr_addr1] <= bus.wr_data1;
            end
        end
    end

    always_comb begin
        rd_data0 = mem_q[bus.rd_addr0];
        rd_data1 = mem_q[bus.rd_addr1];
`ifdef GRF_MP_BYPASS_EN
        // wr_ok* already excludes the sweep and the hardwired zero entry.
        if (wr_ok0 && (bus.wr_addr0 == bus.rd_addr0)) rd_data0 = bus.wr_data0;
        if (wr_ok1 && (bus.wr_addr1 == bus.rd_addr0)) rd_data0 = bus.wr_data1;
        if (wr_ok0 && (bus.wr_addr0 == bus.rd_addr1)) rd_data1 = bus.wr_data0;
        if (wr_ok1 && (bus.wr_addr1 == bus.rd_addr1)) rd_data1 = bus.wr_data1;
`endif
        if ((ZERO_REG == 1) && (bus.rd_addr0 == '0)) rd_data0 = '0;
        if ((ZERO_REG == 1) && (bus.rd_addr1 == '0)) rd_data1 = '0;
    end

    assign bus.rd_data0 = rd_data0;
    assign bus.rd_data1 = rd_data1;
    assign bus.clr_busy = (state_q == StSweep);
    assign bus.clr_done = (state_q == StDone);

endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp: directed self-checking bench for grf_mp (DATA_W=32, ADDR_W=5, ZERO_REG=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
module tb_grf_mp;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    grf_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    grf_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write0(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en0   = 1'b1;
        bus.wr_addr0 = a;
        bus.wr_data0 = d;
        tick();
        bus.wr_en0   = 1'b0;
    endtask

    task automatic read0(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.rd_addr0 = a;
        #1;
        check(tag, bus.rd_data0, exp);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [31:0] bypass_exp;

        n_checks = 0;
        n_errors = 0;
        reset        = 1'b0;
        bus.rd_addr0 = '0;
        bus.rd_addr1 = '0;
        bus.wr_en0   = 1'b0;
        bus.wr_addr0 = '0;
        bus.wr_data0 = '0;
        bus.wr_en1   = 1'b0;
        bus.wr_addr1 = '0;
        bus.wr_data1 = '0;
        bus.clr_req  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check("init_busy", 32'(bus.clr_busy), 32'd0);
        check("init_done", 32'(bus.clr_done), 32'd0);

        // Reset hold
        write0(5'd5, 32'hDEADBEEF);
        read0("r5_written", 5'd5, 32'hDEADBEEF);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        read0("r5_after_reset", 5'd5, 32'h0);
        check("reset_busy", 32'(bus.clr_busy), 32'd0);
        check("reset_done", 32'(bus.clr_done), 32'd0);

        // Dual write, different addresses
        bus.wr_en0 = 1'b1; bus.wr_addr0 = 5'd3; bus.wr_data0 = 32'h11111111;
        bus.wr_en1 = 1'b1; bus.wr_addr1 = 5'd7; bus.wr_data1 = 32'h22222222;
        tick();
        bus.wr_en0 = 1'b0; bus.wr_en1 = 1'b0;
        bus.rd_addr1 = 5'd7;
        read0("dual_r3", 5'd3, 32'h11111111);
        check("dual_r7", bus.rd_data1, 32'h22222222);

        // Same-address conflict: port 1 wins
        bus.wr_en0 = 1'b1; bus.wr_addr0 = 5'd9; bus.wr_data0 = 32'hAAAA0000;
        bus.wr_en1 = 1'b1; bus.wr_addr1 = 5'd9; bus.wr_data1 = 32'h0000BBBB;
        tick();
        bus.wr_en0 = 1'b0; bus.wr_en1 = 1'b0;
        read0("conflict_r9", 5'd9, 32'h0000BBBB);

        // Zero register, same cycle and afterwards
        bus.wr_en0 = 1'b1; bus.wr_addr0 = 5'd0; bus.wr_data0 = 32'hFFFFFFFF;
        read0("r0_same_cycle", 5'd0, 32'h0);
        tick();
        bus.wr_en0 = 1'b0;
        read0("r0_after", 5'd0, 32'h0);

        // Forwarding on read port 1 (r4 is 0 since the reset)
`ifdef GRF_MP_BYPASS_EN
        bypass_exp = 32'h12345678;
`else
        bypass_exp = 32'h00000000;
`endif
        bus.wr_en1 = 1'b1; bus.wr_addr1 = 5'd4; bus.wr_data1 = 32'h12345678;
        bus.rd_addr1 = 5'd4;
        #1;
        check("bypass_same_cycle", bus.rd_data1, bypass_exp);
        tick();
        bus.wr_en1 = 1'b0;
        #1;
        check("bypass_next_cycle", bus.rd_data1, 32'h12345678);

        // Clear sweep with stalled writes held on port 0
        for (int i = 1; i < 32; i++) write0(5'(i), 32'h1000_0000 + 32'(i));
        read0("fill_r31", 5'd31, 32'h1000_001F);
        read0("fill_r1", 5'd1, 32'h1000_0001);
        bus.clr_req = 1'b1;
        tick();                                  // edge T
        bus.clr_req  = 1'b0;
        bus.wr_en0   = 1'b1;
        bus.wr_addr0 = 5'd6;
        bus.wr_data0 = 32'h0000_0055;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.clr_busy) busy_cnt++;
            if (bus.clr_done) begin
                done_cnt++;
                done_at = k;
            end
            bus.wr_en0 = bus.clr_busy;           // stop writing once the sweep ends
            tick();
        end
        bus.wr_en0 = 1'b0;
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd32);
        check("sweep_done_count", 32'(done_cnt), 32'd1);
        check("sweep_done_cycle", 32'(done_at), 32'd33);
        for (int i = 0; i < 32; i++) read0($sformatf("swept_r%0d", i), 5'(i), 32'h0);

        // Reset in the middle of a sweep
        write0(5'd2, 32'hCAFE0002);
        write0(5'd20, 32'hCAFE0014);
        write0(5'd31, 32'hCAFE001F);
        bus.clr_req = 1'b1;
        tick();                                  // edge T
        bus.clr_req = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("mid_sweep_busy", 32'(bus.clr_busy), 32'd1);
        reset = 1'b0;
        tick();                                  // edge T+10
        reset = 1'b1;
        check("abort_busy", 32'(bus.clr_busy), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.clr_done) done_cnt++;
            tick();
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        read0("abort_r2", 5'd2, 32'h0);
        read0("abort_r20", 5'd20, 32'h0);
        read0("abort_r31", 5'd31, 32'h0);
        // An idle engine accepts writes immediately
        write0(5'd8, 32'h0BAD_F00D);
        read0("idle_write_r8", 5'd8, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
